// File: rtl/billiard_pkg.sv
// Shared fixed-point types, table geometry and helpers for the billiard ball logic.
// Positions are 11.6 unsigned fixed point; velocities are signed 1/64 px per frame.
package billiard_pkg;

  localparam int FP_SHIFT  = 6;
  localparam int BALL_SIZE = 32;
  localparam int NUM_AXES  = 2;

  // Cushion limits apply to the ball's top-left corner, so the far side backs off one ball size.
  localparam int TABLE_X_MIN = 32;
  localparam int TABLE_X_MAX = 608 - BALL_SIZE;
  localparam int TABLE_Y_MIN = 32;
  localparam int TABLE_Y_MAX = 448 - BALL_SIZE;

  typedef logic [16:0]        fp_pos_t;
  typedef logic signed [11:0] vel_t;

  typedef enum logic [1:0] {IDLE, MOVING, SUNK} ball_state_t;

  // -2048 has no positive twin; clamp it so a cushion bounce can always negate.
  function automatic vel_t sat_vel(input vel_t v);
    return (v == vel_t'(12'h800)) ? vel_t'(12'h801) : v;
  endfunction

  function automatic fp_pos_t to_fp(input int px);
    return fp_pos_t'(px << FP_SHIFT);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-frame motion step for a single axis: integrate, bounce off the cushions, then
// apply friction to whatever velocity results.
module ball_axis_step
  import billiard_pkg::*;
#(
  parameter int MIN      = 32,
  parameter int MAX      = 576,
  parameter int FRICTION = 1
) (
  input  fp_pos_t pos,
  input  vel_t    vel,
  output fp_pos_t pos_nxt,
  output vel_t    vel_nxt
);

  localparam logic signed [17:0] LO = 18'(MIN << FP_SHIFT);
  localparam logic signed [17:0] HI = 18'(MAX << FP_SHIFT);

  logic signed [17:0] sum;
  vel_t               v_b;
  logic [11:0]        mag;

  always_comb begin
    sum     = $signed({1'b0, pos}) + $signed({{6{vel[11]}}, vel});
    pos_nxt = fp_pos_t'(sum);
    v_b     = vel;
    if (sum < LO) begin
      pos_nxt = fp_pos_t'(LO);
      v_b     = vel_t'(-vel);
    end else if (sum > HI) begin
      pos_nxt = fp_pos_t'(HI);
      v_b     = vel_t'(-vel);
    end
    // Friction pulls toward zero and never overshoots past it.
    mag = v_b[11] ? 12'(-v_b) : 12'(v_b);
    if (mag <= 12'(FRICTION))
      vel_nxt = '0;
    else if (v_b[11])
      vel_nxt = v_b + vel_t'(FRICTION);
    else
      vel_nxt = v_b - vel_t'(FRICTION);
  end

endmodule

// File: rtl/ball_move.sv
// Per-ball motion controller feeding ball_draw: holds fixed-point position/velocity,
// integrates once per frame while MOVING, and hides the ball once it is pocketed.
module ball_move
  import billiard_pkg::*;
#(
  parameter int INIT_X   = 100,
  parameter int INIT_Y   = 200,
  parameter int X_MIN    = TABLE_X_MIN,
  parameter int X_MAX    = TABLE_X_MAX,
  parameter int Y_MIN    = TABLE_Y_MIN,
  parameter int Y_MAX    = TABLE_Y_MAX,
  parameter int FRICTION = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hit,
  input  logic signed [11:0] hitVelX,
  input  logic signed [11:0] hitVelY,
  input  logic               inPocket,
  input  logic               respawn,
  output logic [10:0]        topLeftPosX,
  output logic [10:0]        topLeftPosY,
  output logic               ballShow,
  output logic               moving
);

  ball_state_t                 state;
  fp_pos_t [NUM_AXES-1:0]      pos_q, pos_nxt;
  vel_t    [NUM_AXES-1:0]      vel_q, vel_nxt, vel_hit;

  assign vel_hit[0] = sat_vel(hitVelX);
  assign vel_hit[1] = sat_vel(hitVelY);

  // Axis 0 is X, axis 1 is Y.
  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    ball_axis_step #(
      .MIN      (a == 0 ? X_MIN : Y_MIN),
      .MAX      (a == 0 ? X_MAX : Y_MAX),
      .FRICTION (FRICTION)
    ) u_step (
      .pos     (pos_q[a]),
      .vel     (vel_q[a]),
      .pos_nxt (pos_nxt[a]),
      .vel_nxt (vel_nxt[a])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetN || respawn) begin
      state    <= IDLE;
      pos_q[0] <= to_fp(INIT_X);
      pos_q[1] <= to_fp(INIT_Y);
      vel_q    <= '0;
      ballShow <= 1'b1;
      moving   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-velocity strike leaves the ball at rest.
          if (hit && (hitVelX != '0 || hitVelY != '0)) begin
            vel_q  <= vel_hit;
            state  <= MOVING;
            moving <= 1'b1;
          end
        end
        MOVING: begin
          if (startOfFrame) begin
            if (inPocket) begin
              state    <= SUNK;
              vel_q    <= '0;
              ballShow <= 1'b0;
              moving   <= 1'b0;
            end else begin
              pos_q <= pos_nxt;
              vel_q <= vel_nxt;
              if (vel_nxt == '0) begin
                state  <= IDLE;
                moving <= 1'b0;
              end
            end
          end
        end
        SUNK: ;
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

  assign topLeftPosX = pos_q[0][16:6];
  assign topLeftPosY = pos_q[1][16:6];

endmodule

// File: tb/tb_ball_move.sv
// Directed bench for ball_move: vector tables for single-cycle behaviour plus hand-written
// sequences for the long friction run and cushion bounces (second instance placed near cushions).
module tb_ball_move;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetN, sof, hit, inPocket, respawn;
  logic signed [11:0] vx, vy;
  logic [10:0]        px, py;
  logic               show, mov;

  logic               sof_b, hit_b;
  logic               pocket_b, resp_b;
  logic signed [11:0] vx_b, vy_b;
  logic [10:0]        px_b, py_b;
  logic               show_b, mov_b;

  int checks = 0;
  int errors = 0;

  ball_move dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .hit(hit),
    .hitVelX(vx), .hitVelY(vy), .inPocket(inPocket), .respawn(respawn),
    .topLeftPosX(px), .topLeftPosY(py), .ballShow(show), .moving(mov)
  );

  ball_move #(.INIT_X(570), .INIT_Y(40)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof_b), .hit(hit_b),
    .hitVelX(vx_b), .hitVelY(vy_b), .inPocket(pocket_b), .respawn(resp_b),
    .topLeftPosX(px_b), .topLeftPosY(py_b), .ballShow(show_b), .moving(mov_b)
  );

  typedef struct {
    string nm;
    bit    rstn, hit, sof, pocket, resp;
    int    vx, vy;
    int    ex, ey;
    bit    es, em;
  } vec_t;

  function automatic vec_t mk(string nm, bit rstn, bit h, int x, int y, bit s, bit p, bit r,
                              int ex, int ey, bit es, bit em);
    vec_t v;
    v.nm = nm; v.rstn = rstn; v.hit = h; v.vx = x; v.vy = y; v.sof = s; v.pocket = p;
    v.resp = r; v.ex = ex; v.ey = ey; v.es = es; v.em = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_a(input string nm, input int ex, input int ey, input bit es, input bit em);
    chk({nm, "_x"}, 32'(px), ex);
    chk({nm, "_y"}, 32'(py), ey);
    chk({nm, "_show"}, 32'(show), 32'(es));
    chk({nm, "_moving"}, 32'(mov), 32'(em));
  endtask

  task automatic check_b(input string nm, input int ex, input int ey, input bit es, input bit em);
    chk({nm, "_x"}, 32'(px_b), ex);
    chk({nm, "_y"}, 32'(py_b), ey);
    chk({nm, "_show"}, 32'(show_b), 32'(es));
    chk({nm, "_moving"}, 32'(mov_b), 32'(em));
  endtask

  task automatic apply(input vec_t v);
    int tx, ty;
    tx = v.vx; ty = v.vy;
    resetN = v.rstn; hit = v.hit; sof = v.sof; inPocket = v.pocket; respawn = v.resp;
    vx = tx[11:0]; vy = ty[11:0];
    @(posedge clk); #1;
    check_a(v.nm, v.ex, v.ey, v.es, v.em);
  endtask

  task automatic frame_a();
    resetN = 1'b1; hit = 1'b0; inPocket = 1'b0; respawn = 1'b0; sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic step_b(input bit h, input bit s);
    hit_b = h; sof_b = s;
    @(posedge clk); #1;
    hit_b = 1'b0; sof_b = 1'b0;
  endtask

  vec_t t1[$];
  vec_t t2[$];

  initial begin
    resetN = 1'b0; sof = 1'b0; hit = 1'b0; inPocket = 1'b0; respawn = 1'b0; vx = '0; vy = '0;
    sof_b = 1'b0; hit_b = 1'b0; pocket_b = 1'b0; resp_b = 1'b0; vx_b = '0; vy_b = '0;

    //            name         rstn hit vx     vy   sof pk rsp  ex   ey  show mov
    t1.push_back(mk("reset1",    0, 0,    0,    0,  0, 0, 0, 100, 200, 1, 0));
    t1.push_back(mk("reset2",    0, 0,    0,    0,  0, 0, 0, 100, 200, 1, 0));
    t1.push_back(mk("sof_idle",  1, 0,    0,    0,  1, 0, 0, 100, 200, 1, 0));
    t1.push_back(mk("hit_zero",  1, 1,    0,    0,  0, 0, 0, 100, 200, 1, 0));
    t1.push_back(mk("pk_idle",   1, 0,    0,    0,  1, 1, 0, 100, 200, 1, 0));
    t1.push_back(mk("hit_load",  1, 1,   64,    0,  0, 0, 0, 100, 200, 1, 1));
    t1.push_back(mk("no_sof",    1, 0,    0,    0,  0, 0, 0, 100, 200, 1, 1));
    t1.push_back(mk("frame1",    1, 0,    0,    0,  1, 0, 0, 101, 200, 1, 1));

    t2.push_back(mk("hit_neg",   1, 1, -2048,   5,  0, 0, 0, 132, 200, 1, 1));
    t2.push_back(mk("neg_f1",    1, 0,    0,    0,  1, 0, 0, 100, 200, 1, 1));
    t2.push_back(mk("hit_mov",   1, 1,  100,  100,  0, 0, 0, 100, 200, 1, 1));
    t2.push_back(mk("neg_f2",    1, 0,    0,    0,  1, 0, 0,  68, 200, 1, 1));
    t2.push_back(mk("pocket",    1, 0,    0,    0,  1, 1, 0,  68, 200, 0, 0));
    t2.push_back(mk("sunk_sof",  1, 0,    0,    0,  1, 0, 0,  68, 200, 0, 0));
    t2.push_back(mk("sunk_hit",  1, 1,   64,    0,  0, 0, 0,  68, 200, 0, 0));
    t2.push_back(mk("respawn",   1, 0,    0,    0,  0, 0, 1, 100, 200, 1, 0));
    t2.push_back(mk("resp_hit",  1, 1,   64,    0,  0, 0, 1, 100, 200, 1, 0));
    t2.push_back(mk("resp_sof",  1, 0,    0,    0,  1, 0, 0, 100, 200, 1, 0));
    t2.push_back(mk("hit_sof",   1, 1,  -64,  -64,  1, 0, 0, 100, 200, 1, 1));
    t2.push_back(mk("hs_f1",     1, 0,    0,    0,  1, 0, 0,  99, 199, 1, 1));
    t2.push_back(mk("rst_mid",   0, 0,    0,    0,  1, 0, 0, 100, 200, 1, 0));
    t2.push_back(mk("rst_sof",   1, 0,    0,    0,  1, 0, 0, 100, 200, 1, 0));

    foreach (t1[i]) apply(t1[i]);

    // Velocity 64 decays by one per frame; total travel 64+63+...+1 = 2080/64 px.
    for (int f = 2; f <= 64; f++) begin
      frame_a();
      if (f == 2)  check_a("frame2", 101, 200, 1, 1);
      if (f == 63) check_a("frame63", 132, 200, 1, 1);
      if (f == 64) check_a("frame64", 132, 200, 1, 0);
    end

    foreach (t2[i]) apply(t2[i]);
    resetN = 1'b1; sof = 1'b0; hit = 1'b0;

    // Second ball starts beside the right and top cushions.
    check_b("b_reset", 570, 40, 1, 0);
    vx_b = 12'sd640; vy_b = -12'sd640;
    step_b(1'b1, 1'b0);
    check_b("b_hit", 570, 40, 1, 1);
    step_b(1'b0, 1'b1);
    check_b("b_bounce", 576, 32, 1, 1);
    step_b(1'b0, 1'b1);
    check_b("b_after1", 566, 41, 1, 1);
    step_b(1'b0, 1'b1);
    check_b("b_after2", 556, 51, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
